// File: rtl/fl_frame_checker.sv
// FrameLink protocol checker: zero-latency pass-through with sticky error flags.
// Define FL_CHECKER_STATS_EN to build the frame/byte statistics counters.
module fl_frame_checker #(
    parameter int DATA_WIDTH      = 64,
    parameter int DREM_WIDTH      = $clog2(DATA_WIDTH / 8),
    parameter int PARTS           = 1,
    parameter int MAX_FRAME_BYTES = 16384
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [DREM_WIDTH-1:0] i_rx_rem,
    input  logic                  i_rx_sof_n,
    input  logic                  i_rx_eof_n,
    input  logic                  i_rx_sop_n,
    input  logic                  i_rx_eop_n,
    input  logic                  i_rx_src_rdy_n,
    output logic                  o_rx_dst_rdy_n,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [DREM_WIDTH-1:0] o_tx_rem,
    output logic                  o_tx_sof_n,
    output logic                  o_tx_eof_n,
    output logic                  o_tx_sop_n,
    output logic                  o_tx_eop_n,
    output logic                  o_tx_src_rdy_n,
    input  logic                  i_tx_dst_rdy_n,
    input  logic                  i_err_clr,
    output logic [4:0]            o_err_flags,
    output logic                  o_err_pulse,
    output logic [31:0]           o_stat_frames,
    output logic [31:0]           o_stat_bytes
);

    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int BYTES_W        = $clog2(BYTES_PER_WORD + 1);
    localparam int LEN_W          = $clog2(MAX_FRAME_BYTES + 2);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_FRAME_BYTES + 1);

    typedef enum logic [1:0] {S_IDLE, S_IN_PART, S_GAP} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [LEN_W-1:0]   r_len;
    logic [3:0]         r_parts;
    logic [4:0]         r_err_flags;
    logic               r_err_pulse;

    logic               w_xfer, w_sof, w_eof, w_sop, w_eop;
    logic               w_accept;
    logic [BYTES_W-1:0] w_word_bytes;
    logic [LEN_W-1:0]   w_len_base;
    logic [LEN_W-1:0]   w_len_now;
    logic [31:0]        w_len_sum;
    logic [3:0]         w_parts_now;
    logic [4:0]         w_err_new;

    // Pass-through is pure wiring so it stays live while reset is asserted.
    assign o_tx_data      = i_rx_data;
    assign o_tx_rem       = i_rx_rem;
    assign o_tx_sof_n     = i_rx_sof_n;
    assign o_tx_eof_n     = i_rx_eof_n;
    assign o_tx_sop_n     = i_rx_sop_n;
    assign o_tx_eop_n     = i_rx_eop_n;
    assign o_tx_src_rdy_n = i_rx_src_rdy_n;
    assign o_rx_dst_rdy_n = i_tx_dst_rdy_n;

    assign w_xfer = !i_rx_src_rdy_n && !i_tx_dst_rdy_n;
    assign w_sof  = !i_rx_sof_n;
    assign w_eof  = !i_rx_eof_n;
    assign w_sop  = !i_rx_sop_n;
    assign w_eop  = !i_rx_eop_n;

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin : p_state_reg
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    // A SOF word always (re)starts a frame; ignored words leave the state alone.
    always_comb begin : p_next_state
        w_next_state = r_state;
        if (w_accept) begin
            if (w_eof)      w_next_state = S_IDLE;
            else if (w_eop) w_next_state = S_GAP;
            else            w_next_state = S_IN_PART;
        end
    end

    // NOTE: every signal gets a default first so this block can never infer a latch.
    always_comb begin : p_outputs
        w_accept = w_xfer && (w_sof || r_state == S_IN_PART || (r_state == S_GAP && w_sop));
        w_word_bytes = w_eop ? BYTES_W'(i_rx_rem) + BYTES_W'(1) : BYTES_W'(BYTES_PER_WORD);

        w_parts_now = r_parts;
        if (w_sof)
            w_parts_now = 4'd1;
        else if (r_state == S_GAP && w_sop && r_parts != 4'd15)
            w_parts_now = r_parts + 4'd1;

        w_len_base = w_sof ? '0 : r_len;
        w_len_sum  = 32'(w_len_base) + 32'(w_word_bytes);
        w_len_now  = (w_len_sum > 32'(MAX_FRAME_BYTES)) ? LEN_SAT : w_len_sum[LEN_W-1:0];

        w_err_new = '0;
        if (w_xfer) begin
            w_err_new[0] = w_sof && r_state != S_IDLE;
            w_err_new[1] = !w_sof && (r_state == S_IDLE || (r_state == S_GAP && !w_sop));
            w_err_new[2] = (w_sof && !w_sop) || (w_eof && !w_eop);
        end
        if (w_accept) begin
            w_err_new[3] = w_eof && (w_parts_now != 4'(PARTS));
            // Base still within limit means this is the first word to cross it.
            w_err_new[4] = (w_len_sum > 32'(MAX_FRAME_BYTES)) &&
                           (32'(w_len_base) <= 32'(MAX_FRAME_BYTES));
        end
    end

    always_ff @(posedge i_clk) begin : p_track
        if (i_reset) begin
            r_len       <= '0;
            r_parts     <= '0;
            r_err_flags <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            if (w_accept) begin
                r_len   <= w_len_now;
                r_parts <= w_parts_now;
            end
            r_err_flags <= (i_err_clr ? 5'b0 : r_err_flags) | w_err_new;
            r_err_pulse <= |w_err_new;
        end
    end

    assign o_err_flags = r_err_flags;
    assign o_err_pulse = r_err_pulse;

`ifdef FL_CHECKER_STATS_EN
    logic [31:0] r_stat_frames;
    logic [31:0] r_stat_bytes;

    // Frames count accepted EOF words; bytes count every word that crossed the link.
    always_ff @(posedge i_clk) begin : p_stats
        if (i_reset) begin
            r_stat_frames <= '0;
            r_stat_bytes  <= '0;
        end else begin
            if (w_accept && w_eof) r_stat_frames <= r_stat_frames + 32'd1;
            if (w_xfer)            r_stat_bytes  <= r_stat_bytes + 32'(w_word_bytes);
        end
    end

    assign o_stat_frames = r_stat_frames;
    assign o_stat_bytes  = r_stat_bytes;
`else
    assign o_stat_frames = 32'd0;
    assign o_stat_bytes  = 32'd0;
`endif

endmodule

// File: tb/tb_fl_frame_checker.sv
// Directed self-checking bench for fl_frame_checker (64-bit, PARTS=1).
// A second instance with MAX_FRAME_BYTES=32 exercises the length limit.
module tb_fl_frame_checker;

`ifdef FL_CHECKER_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif
    localparam logic [63:0] PT_DATA = 64'h0123_4567_89AB_CDEF;

    logic        clk, reset;
    logic [63:0] rx_data;
    logic [2:0]  rx_rem;
    logic        rx_sof_n, rx_eof_n, rx_sop_n, rx_eop_n, rx_src_rdy_n;
    logic        tx_dst_rdy_n, err_clr;

    logic        rx_dst_rdy_n;
    logic [63:0] tx_data;
    logic [2:0]  tx_rem;
    logic        tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n, tx_src_rdy_n;
    logic [4:0]  err_flags;
    logic        err_pulse;
    logic [31:0] stat_frames, stat_bytes;

    logic        s_rx_dst_rdy_n;
    logic [63:0] s_tx_data;
    logic [2:0]  s_tx_rem;
    logic        s_tx_sof_n, s_tx_eof_n, s_tx_sop_n, s_tx_eop_n, s_tx_src_rdy_n;
    logic [4:0]  s_err_flags;
    logic        s_err_pulse;
    logic [31:0] s_stat_frames, s_stat_bytes;

    int n_checks = 0;
    int n_errors = 0;

    fl_frame_checker dut (
        .i_clk(clk), .i_reset(reset),
        .i_rx_data(rx_data), .i_rx_rem(rx_rem),
        .i_rx_sof_n(rx_sof_n), .i_rx_eof_n(rx_eof_n),
        .i_rx_sop_n(rx_sop_n), .i_rx_eop_n(rx_eop_n),
        .i_rx_src_rdy_n(rx_src_rdy_n), .o_rx_dst_rdy_n(rx_dst_rdy_n),
        .o_tx_data(tx_data), .o_tx_rem(tx_rem),
        .o_tx_sof_n(tx_sof_n), .o_tx_eof_n(tx_eof_n),
        .o_tx_sop_n(tx_sop_n), .o_tx_eop_n(tx_eop_n),
        .o_tx_src_rdy_n(tx_src_rdy_n), .i_tx_dst_rdy_n(tx_dst_rdy_n),
        .i_err_clr(err_clr), .o_err_flags(err_flags), .o_err_pulse(err_pulse),
        .o_stat_frames(stat_frames), .o_stat_bytes(stat_bytes)
    );

    fl_frame_checker #(.MAX_FRAME_BYTES(32)) dut_s (
        .i_clk(clk), .i_reset(reset),
        .i_rx_data(rx_data), .i_rx_rem(rx_rem),
        .i_rx_sof_n(rx_sof_n), .i_rx_eof_n(rx_eof_n),
        .i_rx_sop_n(rx_sop_n), .i_rx_eop_n(rx_eop_n),
        .i_rx_src_rdy_n(rx_src_rdy_n), .o_rx_dst_rdy_n(s_rx_dst_rdy_n),
        .o_tx_data(s_tx_data), .o_tx_rem(s_tx_rem),
        .o_tx_sof_n(s_tx_sof_n), .o_tx_eof_n(s_tx_eof_n),
        .o_tx_sop_n(s_tx_sop_n), .o_tx_eop_n(s_tx_eop_n),
        .o_tx_src_rdy_n(s_tx_src_rdy_n), .i_tx_dst_rdy_n(tx_dst_rdy_n),
        .i_err_clr(err_clr), .o_err_flags(s_err_flags), .o_err_pulse(s_err_pulse),
        .o_stat_frames(s_stat_frames), .o_stat_bytes(s_stat_bytes)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] st(input int unsigned v);
        return STATS_ON ? 64'(v) : 64'd0;
    endfunction

    // One transfer with the given active-low controls, then the link goes idle.
    task automatic send(input logic sof_n, input logic sop_n, input logic eop_n,
                        input logic eof_n, input logic [2:0] rem);
        rx_data      = {$urandom, $urandom};
        rx_rem       = rem;
        rx_sof_n     = sof_n;
        rx_sop_n     = sop_n;
        rx_eop_n     = eop_n;
        rx_eof_n     = eof_n;
        rx_src_rdy_n = 1'b0;
        @(posedge clk);
        #1;
        rx_src_rdy_n = 1'b1;
        rx_sof_n = 1'b1; rx_sop_n = 1'b1; rx_eop_n = 1'b1; rx_eof_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; err_clr = 1'b0;
        rx_data = PT_DATA; rx_rem = 3'd5;
        rx_sof_n = 1'b0; rx_eof_n = 1'b1; rx_sop_n = 1'b1; rx_eop_n = 1'b1;
        rx_src_rdy_n = 1'b0; tx_dst_rdy_n = 1'b1;

        // Pass-through while reset is held
        #1;
        check("pt_data", tx_data, PT_DATA);
        check("pt_rem", 64'(tx_rem), 64'd5);
        check("pt_sof", 64'(tx_sof_n), 64'd0);
        check("pt_src_rdy", 64'(tx_src_rdy_n), 64'd0);
        check("pt_dst_rdy", 64'(rx_dst_rdy_n), 64'd1);
        rx_src_rdy_n = 1'b1; rx_sof_n = 1'b1; tx_dst_rdy_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_flags", 64'(err_flags), 64'd0);
        check("rst_pulse", 64'(err_pulse), 64'd0);
        check("rst_frames", 64'(stat_frames), 64'd0);
        check("rst_bytes", 64'(stat_bytes), 64'd0);

        // Five-word frame, REM=3, with a 10-cycle stall carrying a SOF word
        send(1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        send(1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
        tx_dst_rdy_n = 1'b1; rx_src_rdy_n = 1'b0; rx_sof_n = 1'b0; rx_sop_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_pulse", 64'(err_pulse), 64'd0);
        end
        rx_src_rdy_n = 1'b1; rx_sof_n = 1'b1; rx_sop_n = 1'b1; tx_dst_rdy_n = 1'b0;
        check("stall_flags", 64'(err_flags), 64'd0);
        check("stall_bytes", 64'(stat_bytes), st(16));
        send(1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
        send(1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
        check("len32_w4_flags", 64'(s_err_flags), 64'd0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
        check("f5_flags", 64'(err_flags), 64'd0);
        check("f5_pulse", 64'(err_pulse), 64'd0);
        check("f5_frames", 64'(stat_frames), st(1));
        check("f5_bytes", 64'(stat_bytes), st(36));
        check("len32_w5_flags", 64'(s_err_flags), 64'h10);

        // Second SOF without EOF restarts; the restarted frame completes
        do_reset();
        send(1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        send(1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        check("dup_sof_flags", 64'(err_flags), 64'h01);
        check("dup_sof_pulse", 64'(err_pulse), 64'd1);
        tick();
        check("dup_sof_pulse_drop", 64'(err_pulse), 64'd0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 3'd7);
        check("dup_sof_end_flags", 64'(err_flags), 64'h01);
        check("dup_sof_frames", 64'(stat_frames), st(1));
        check("dup_sof_bytes", 64'(stat_bytes), st(24));

        // Word without SOF in IDLE is ignored; ERR_CLR alone clears
        do_reset();
        send(1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
        check("no_sof_flags", 64'(err_flags), 64'h02);
        check("no_sof_frames", 64'(stat_frames), 64'd0);
        send(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        check("single_sticky", 64'(err_flags), 64'h02);
        check("single_frames", 64'(stat_frames), st(1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_flags", 64'(err_flags), 64'd0);

        // Two-part frame with PARTS=1; stray non-SOP word in GAP
        do_reset();
        send(1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
        send(1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
        check("gap_no_sop_flags", 64'(err_flags), 64'h02);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        send(1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        check("parts_flags", 64'(err_flags), 64'h08);
        check("parts_pulse", 64'(err_pulse), 64'd1);
        check("parts_frames", 64'(stat_frames), st(1));

        // SOF/SOP and EOF/EOP mismatches; ERR_CLR with concurrent SOF error
        do_reset();
        send(1'b0, 1'b1, 1'b1, 1'b1, 3'd0);
        check("sof_nosop_flags", 64'(err_flags), 64'h04);
        err_clr = 1'b1;
        send(1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        err_clr = 1'b0;
        check("clr_vs_sof_flags", 64'(err_flags), 64'h01);
        send(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        check("eof_noeop_flags", 64'(err_flags), 64'h05);
        check("eof_noeop_frames", 64'(stat_frames), st(1));
        do_reset();
        send(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        check("multi_flags", 64'(err_flags), 64'h06);
        check("multi_pulse", 64'(err_pulse), 64'd1);
        tick();
        check("multi_pulse_drop", 64'(err_pulse), 64'd0);

        // Reset mid-frame abandons it silently
        do_reset();
        send(1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        send(1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
        do_reset();
        check("midrst_flags", 64'(err_flags), 64'd0);
        send(1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
        check("midrst_new_flags", 64'(err_flags), 64'd0);
        check("midrst_frames", 64'(stat_frames), st(1));
        check("midrst_bytes", 64'(stat_bytes), st(5));

        // Six full words against a 32-byte limit: flagged once, at word 5
        do_reset();
        send(1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
        check("lim_w4_flags", 64'(s_err_flags), 64'd0);
        send(1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
        check("lim_w5_flags", 64'(s_err_flags), 64'h10);
        check("lim_w5_pulse", 64'(s_err_pulse), 64'd1);
        send(1'b1, 1'b1, 1'b0, 1'b0, 3'd7);
        check("lim_w6_pulse", 64'(s_err_pulse), 64'd0);
        check("lim_w6_flags", 64'(s_err_flags), 64'h10);
        check("lim_big_flags", 64'(err_flags), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
